// File: rtl/seg_display_driver_if.sv
// =============================================================================
// Module      : seg_display_driver_if
// Description : Bundles the cpu-facing and board-facing signals of the
//               front-panel driver.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface seg_display_driver_if;
   logic [15:0] data_in;
   logic [7:0]  pc_in;
   logic        step_btn;
   logic        run_mode;
   logic        cpu_enable;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [7:0]  led;

   // master = cpu/board side, slave = the display driver
   modport master (
      output data_in, pc_in, step_btn, run_mode,
      input  cpu_enable, seg_n, an_n, led
   );

   modport slave (
      input  data_in, pc_in, step_btn, run_mode,
      output cpu_enable, seg_n, an_n, led
   );
endinterface

`default_nettype wire

// File: rtl/seg_display_driver.sv
// =============================================================================
// Module      : seg_display_driver
// Description : Front-panel output stage: 4-digit multiplexed hex display,
//               PC LEDs and debounced single-step cpu_enable generation.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module seg_display_driver #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  wire logic           clk,
   input  wire logic           reset_n,
   seg_display_driver_if.slave bus
);

   localparam logic [15:0] c_div_last = 16'(SCAN_DIV - 1);
   localparam logic [19:0] c_db_last  = 20'(DEBOUNCE_CYCLES - 1);

   logic        sync1_q,      sync1_d;
   logic        btn_s_q,      btn_s_d;
   logic        btn_db_q,     btn_db_d;
   logic        btn_db_dly_q, btn_db_dly_d;
   logic [19:0] db_cnt_q,     db_cnt_d;
   logic [15:0] div_cnt_q,    div_cnt_d;
   logic [1:0]  dig_idx_q,    dig_idx_d;
   logic [15:0] disp_q,       disp_d;
   logic [7:0]  led_q,        led_d;
   logic [3:0]  an_n_q,       an_n_d;
   logic [6:0]  seg_n_q,      seg_n_d;
   logic        cpu_enable_q, cpu_enable_d;
   logic [3:0]  nibble;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   always_comb begin
      sync1_d = bus.step_btn;
      btn_s_d = sync1_q;

      // A level change is accepted only after it has been seen unbroken
      // for DEBOUNCE_CYCLES cycles; any agreement restarts the count.
      btn_db_d = btn_db_q;
      db_cnt_d = '0;
      if (btn_s_q != btn_db_q) begin
         if (db_cnt_q == c_db_last) begin
            btn_db_d = btn_s_q;
         end else begin
            db_cnt_d = db_cnt_q + 20'd1;
         end
      end

      btn_db_dly_d = btn_db_q;
      cpu_enable_d = bus.run_mode | (btn_db_q & ~btn_db_dly_q);
   end

   always_comb begin
      div_cnt_d = div_cnt_q + 16'd1;
      dig_idx_d = dig_idx_q;
      if (div_cnt_q == c_div_last) begin
         div_cnt_d = '0;
         dig_idx_d = dig_idx_q + 2'd1;
      end

      disp_d = bus.data_in;
      led_d  = bus.pc_in;

      // Anode and segment pattern come from the same dig_idx on the same
      // edge, so a digit never shows its neighbour's pattern.
      nibble  = disp_q[{dig_idx_q, 2'b00} +: 4];
      an_n_d  = ~(4'b0001 << dig_idx_q);
      seg_n_d = hex_to_seg(nibble);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q      <= 1'b0;
         btn_s_q      <= 1'b0;
         btn_db_q     <= 1'b0;
         btn_db_dly_q <= 1'b0;
         db_cnt_q     <= '0;
         div_cnt_q    <= '0;
         dig_idx_q    <= '0;
         disp_q       <= '0;
         led_q        <= '0;
         an_n_q       <= 4'hF;
         seg_n_q      <= 7'h7F;
         cpu_enable_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         btn_s_q      <= btn_s_d;
         btn_db_q     <= btn_db_d;
         btn_db_dly_q <= btn_db_dly_d;
         db_cnt_q     <= db_cnt_d;
         div_cnt_q    <= div_cnt_d;
         dig_idx_q    <= dig_idx_d;
         disp_q       <= disp_d;
         led_q        <= led_d;
         an_n_q       <= an_n_d;
         seg_n_q      <= seg_n_d;
         cpu_enable_q <= cpu_enable_d;
      end
   end

   assign bus.cpu_enable = cpu_enable_q;
   assign bus.seg_n      = seg_n_q;
   assign bus.an_n       = an_n_q;
   assign bus.led        = led_q;

endmodule

`default_nettype wire

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Front-panel output stage directly downstream of the TSC cpu.
- Consumes the cpu's 16-bit output_port and 8-bit PC_below8bit and drives the board outputs:
  - a 4-digit multiplexed hex seven-segment display;
  - 8 PC LEDs.
- Generates the cpu_enable strobe from a debounced single-step push-button, or holds it high in free-run mode.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit is lit. Legal range 2..65535.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change. Legal range 2..2^20-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- data_in  input  16  value to display (cpu output_port).
- pc_in  input  8  cpu PC_below8bit.
- step_btn  input  1  raw, asynchronous, bouncing push-button; high = pressed.
- run_mode  input  1  1 = free-run, 0 = single-step.
- cpu_enable  output  1  enable to cpu (registered).
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low (registered).
- an_n  output  4  digit anodes, active-low; an_n[0] is the rightmost digit (registered).
- led  output  8  PC LEDs (registered).

Behaviour:
- Reset (reset_n=0 at a clk edge) sets:
  - cpu_enable=0, seg_n=7'h7F (blank), an_n=4'hF, led=8'h00;
  - synchronizer flops, debounced level and all counters to 0;
  - digit index to 0, display register to 16'h0000.
- Reset dominates every other event in the same cycle. Reset asserted mid-scan or mid-debounce discards all progress.
- Capture: each cycle, disp_reg<=data_in and led<=pc_in. led therefore lags pc_in by 1 cycle.
- Scan timing:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap cycle, dig_idx (2 bits) increments and wraps 3->0.
  - Each digit is therefore active for exactly SCAN_DIV cycles; one full frame is 4*SCAN_DIV cycles.
- Output register stage: each cycle, an_n and seg_n are recomputed from the current dig_idx and disp_reg.
  - an_n = ~(4'b0001<<dig_idx).
  - seg_n = hex decode of nibble disp_reg[4*dig_idx+3 : 4*dig_idx].
  - Latency: data_in -> seg_n is 2 cycles; dig_idx change -> an_n/seg_n is 1 cycle.
  - an_n and seg_n always change on the same edge, so no ghosting.
- Hex decode (seg_n values, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78;
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- First cycle after reset release: the output stage loads from dig_idx=0, giving an_n=4'b1110 and seg_n=7'h40. Digit 1 becomes active after SCAN_DIV cycles.
- Button synchronizer: two flops, btn_s = second stage.
- Debounce:
  - While btn_s==btn_db, db_cnt is held at 0.
  - While btn_s!=btn_db, db_cnt increments each cycle.
  - When db_cnt reaches DEBOUNCE_CYCLES-1, btn_db<=btn_s and db_cnt<=0.
  - Any return to equality before that point resets db_cnt to 0. Bounces shorter than DEBOUNCE_CYCLES are ignored.
- cpu_enable generation:
  - run_mode=1: cpu_enable<=1 every cycle. Button events are ignored but debounce tracking continues.
  - run_mode=0: cpu_enable<=1 for exactly one cycle on each 0->1 transition of btn_db; otherwise 0.
  - A release (1->0) produces no pulse.
  - Holding the button produces exactly one pulse.
- run_mode switching:
  - run_mode 1->0 drops cpu_enable to 0 on the next edge.
  - A btn_db rising edge in the same cycle as run_mode 1->0 still produces a 1-cycle pulse. Because cpu_enable was already high, it deasserts one cycle later.
- run_mode is treated as quasi-static. It is not synchronized here; the top level synchronizes it.

Test Plan:
- Reset: reset_n=0 for 3 cycles with data_in=16'hFFFF and step_btn=1 -> cpu_enable=0, an_n=F, seg_n=7F, led=00 throughout. After release, next edge gives an_n=E, seg_n=40.
- Scan/decode: SCAN_DIV=4, data_in=16'h1A2F held -> over 16-cycle frames the display shows:
  - an_n=E/seg_n=0E;
  - an_n=D/seg_n=24;
  - an_n=B/seg_n=08;
  - an_n=7/seg_n=79;
  - each for 4 cycles, repeating.
- Data/LED latency: pc_in 8'h05->8'h06 at edge k -> led=06 from edge k+1. data_in change -> seg_n change at edge k+2 when on the active digit.
- Debounce rejection: DEBOUNCE_CYCLES=8, run_mode=0, step_btn high for 5 cycles, low 3, high 5, low -> cpu_enable never asserts.
- Single step: DEBOUNCE_CYCLES=8, step_btn held high 40 cycles, then low 40, then high again -> exactly one 1-cycle cpu_enable pulse per press.
  - Each pulse occurs 2 (sync) + 8 (debounce) + 1 (output) cycles after the press.
  - Release produces no pulse.
- Run mode and mid-op reset: run_mode=1 -> cpu_enable=1 continuously. Asserting reset_n=0 mid-frame -> cpu_enable=0, display blank, dig_idx=0. After release, run resumes from digit 0.
